// File: rtl/h14tx_island_scheduler.sv
// h14tx_island_scheduler_pkg: shared period type for the island scheduler.
package h14tx_island_scheduler_pkg;

  // Per-clock period classification presented to the TMDS encoder.
  typedef enum logic [1:0] {
    Control            = 2'd0,
    DataIslandPreamble = 2'd1,
    DataIslandGuard    = 2'd2,
    DataIslandActive   = 2'd3
  } period_t;

endpackage

// h14tx_island_scheduler
// Schedules one HDMI data island per line in horizontal blanking:
// 4 clk control lead, 8 clk preamble, 2 clk guard, N x 32 clk packets,
// 2 clk trailing guard. All outputs are registered (1 clk after the x
// they describe).
// Ports:
//   clk, rst_n    - clock, async active-low reset
//   x             - horizontal position, 0..FrameWidth-1
//   enable        - permits opening an island at x == ActiveWidth
//   max_packets   - runtime packet limit, sampled at island open
//   pkt_valid     - upstream has a packet
//   pkt_take      - pulse on the first clock of each packet (consume)
//   pkt_index     - packet number within island (0 outside ACTIVE)
//   pkt_clk       - clock within packet 0..31 (0 outside ACTIVE)
//   timings       - period classification
//   busy          - scheduler not idle
module h14tx_island_scheduler
  import h14tx_island_scheduler_pkg::*;
#(
  parameter int unsigned BitWidth    = 11,
  parameter int unsigned FrameWidth  = 1650,
  parameter int unsigned ActiveWidth = 1280,
  parameter int unsigned HardLimit   = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BitWidth-1:0] x,
  input  logic                enable,
  input  logic [4:0]          max_packets,
  input  logic                pkt_valid,
  output logic                pkt_take,
  output logic [4:0]          pkt_index,
  output logic [4:0]          pkt_clk,
  output period_t             timings,
  output logic                busy
);

  localparam int unsigned PacketsFit = (FrameWidth - ActiveWidth - 30) / 32;
  localparam int unsigned MaxPackets = (PacketsFit < HardLimit) ? PacketsFit : HardLimit;
  localparam logic [4:0]  MaxPktW    = 5'(MaxPackets);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_LEAD_CTRL   = 3'd1;
  localparam logic [2:0] S_PREAMBLE    = 3'd2;
  localparam logic [2:0] S_LEAD_GUARD  = 3'd3;
  localparam logic [2:0] S_ACTIVE      = 3'd4;
  localparam logic [2:0] S_TRAIL_GUARD = 3'd5;
  localparam logic [2:0] S_DONE        = 3'd6;

  logic [2:0] state_q, state_d;
  logic [4:0] phase_q, phase_d;
  logic [4:0] index_q, index_d;
  logic [4:0] lim_q,   lim_d;

  period_t    timings_q, timings_d;
  logic       take_q,    take_d;
  logic [4:0] pidx_q,    pidx_d;
  logic [4:0] pclk_q,    pclk_d;
  logic       busy_q,    busy_d;

  // State in effect for the x currently presented (open/abort folded in)
  logic [2:0] eff_state_c;
  logic [4:0] eff_phase_c;
  logic [4:0] eff_index_c;

  logic [4:0] lim_c;
  logic       open_c;
  logic       x_zero_c;

  assign lim_c    = (max_packets < MaxPktW) ? max_packets : MaxPktW;
  assign x_zero_c = (x == '0);
  assign open_c   = (x == BitWidth'(ActiveWidth)) && enable && pkt_valid && (lim_c != 5'd0);

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= 5'd0;
      index_q   <= 5'd0;
      lim_q     <= 5'd0;
      timings_q <= Control;
      take_q    <= 1'b0;
      pidx_q    <= 5'd0;
      pclk_q    <= 5'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      index_q   <= index_d;
      lim_q     <= lim_d;
      timings_q <= timings_d;
      take_q    <= take_d;
      pidx_q    <= pidx_d;
      pclk_q    <= pclk_d;
      busy_q    <= busy_d;
    end
  end

  // Resolve the current cycle: x == 0 aborts, an open cycle is LEAD_CTRL cycle 1
  always_comb begin
    eff_state_c = state_q;
    eff_phase_c = phase_q;
    eff_index_c = index_q;
    lim_d       = lim_q;
    if ((state_q != S_IDLE) && x_zero_c) begin
      eff_state_c = S_IDLE;
      eff_phase_c = 5'd0;
      eff_index_c = 5'd0;
    end else if ((state_q == S_IDLE) && open_c) begin
      eff_state_c = S_LEAD_CTRL;
      eff_phase_c = 5'd0;
      eff_index_c = 5'd0;
      lim_d       = lim_c;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d   = eff_state_c;
    phase_d   = eff_phase_c + 5'd1;
    index_d   = eff_index_c;
    timings_d = Control;
    take_d    = 1'b0;
    pidx_d    = 5'd0;
    pclk_d    = 5'd0;
    busy_d    = (eff_state_c != S_IDLE);

    case (eff_state_c)
      S_IDLE: begin
        phase_d = 5'd0;
        index_d = 5'd0;
      end
      S_LEAD_CTRL: begin
        if (eff_phase_c == 5'd3) begin
          state_d = S_PREAMBLE;
          phase_d = 5'd0;
        end
      end
      S_PREAMBLE: begin
        timings_d = DataIslandPreamble;
        if (eff_phase_c == 5'd7) begin
          state_d = S_LEAD_GUARD;
          phase_d = 5'd0;
        end
      end
      S_LEAD_GUARD: begin
        timings_d = DataIslandGuard;
        if (eff_phase_c == 5'd1) begin
          state_d = S_ACTIVE;
          phase_d = 5'd0;
          index_d = 5'd0;
        end
      end
      S_ACTIVE: begin
        timings_d = DataIslandActive;
        take_d    = (eff_phase_c == 5'd0);
        pidx_d    = eff_index_c;
        pclk_d    = eff_phase_c;
        if (eff_phase_c == 5'd31) begin
          phase_d = 5'd0;
          // Chain another packet only if one is ready and the limit allows it
          if (pkt_valid && ((6'(eff_index_c) + 6'd1) < 6'(lim_q))) begin
            index_d = eff_index_c + 5'd1;
          end else begin
            state_d = S_TRAIL_GUARD;
            index_d = 5'd0;
          end
        end
      end
      S_TRAIL_GUARD: begin
        timings_d = DataIslandGuard;
        if (eff_phase_c == 5'd1) begin
          state_d = S_DONE;
          phase_d = 5'd0;
        end
      end
      S_DONE: begin
        // Leaves on x == 0 through the abort path above
        phase_d = 5'd0;
      end
      default: begin
        state_d = S_IDLE;
        phase_d = 5'd0;
        index_d = 5'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign timings   = timings_q;
  assign pkt_take  = take_q;
  assign pkt_index = pidx_q;
  assign pkt_clk   = pclk_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_h14tx_island_scheduler.sv
// Scoreboard bench for h14tx_island_scheduler: a line-offset reference
// model pushes the expected registered outputs each clock, a monitor pops
// and compares them one clock later.
module tb_h14tx_island_scheduler;
  import h14tx_island_scheduler_pkg::*;

  localparam int FW   = 1650;
  localparam int AW   = 1280;
  localparam int HL   = 18;
  localparam int FIT  = (FW - AW - 30) / 32;
  localparam int MAXP = (FIT < HL) ? FIT : HL;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] x;
  logic        enable;
  logic [4:0]  max_packets;
  logic        pkt_valid;
  logic        pkt_take;
  logic [4:0]  pkt_index;
  logic [4:0]  pkt_clk;
  period_t     timings;
  logic        busy;

  typedef struct packed {
    period_t    tim;
    logic       take;
    logic [4:0] idx;
    logic [4:0] pc;
    logic       bsy;
  } obs_t;

  obs_t expq[$];
  int   total = 0;
  int   bad   = 0;
  int   takes = 0;

  // Reference model: island described by offset since the open cycle
  bit m_on  = 1'b0;
  int m_off = 0;
  int m_npk = 0;
  int m_lim = 0;

  h14tx_island_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x           (x),
    .enable      (enable),
    .max_packets (max_packets),
    .pkt_valid   (pkt_valid),
    .pkt_take    (pkt_take),
    .pkt_index   (pkt_index),
    .pkt_clk     (pkt_clk),
    .timings     (timings),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic model_loop();
    obs_t e;
    int   a;
    int   lm;
    forever begin
      @(posedge clk);
      e.tim = Control; e.take = 1'b0; e.idx = 5'd0; e.pc = 5'd0; e.bsy = 1'b0;
      lm = (int'(max_packets) < MAXP) ? int'(max_packets) : MAXP;
      if (!rst_n) begin
        m_on = 1'b0;
      end else begin
        if (m_on && x == 11'd0) m_on = 1'b0;
        else if (!m_on && int'(x) == AW && enable && pkt_valid && lm != 0) begin
          m_on = 1'b1; m_off = 0; m_npk = 1; m_lim = lm;
        end else if (m_on) m_off++;
        if (m_on) begin
          e.bsy = 1'b1;
          a = m_off - 14;
          if (m_off < 4)        e.tim = Control;
          else if (m_off < 12)  e.tim = DataIslandPreamble;
          else if (m_off < 14)  e.tim = DataIslandGuard;
          else if (a < 32 * m_npk) begin
            e.tim  = DataIslandActive;
            e.idx  = 5'(a / 32);
            e.pc   = 5'(a % 32);
            e.take = (a % 32 == 0);
            if (a % 32 == 31 && pkt_valid && m_npk < m_lim) m_npk++;
          end else if (a < 32 * m_npk + 2) e.tim = DataIslandGuard;
          else e.tim = Control;
        end
      end
      expq.push_back(e);
    end
  endtask

  task automatic monitor_loop();
    obs_t e;
    obs_t g;
    forever begin
      @(posedge clk);
      #1;
      g.tim = timings; g.take = pkt_take; g.idx = pkt_index; g.pc = pkt_clk; g.bsy = busy;
      if (pkt_take) takes++;
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL sb_empty at x=%0d", x);
      end else begin
        e = expq.pop_front();
        if (g !== e) begin
          bad++;
          $display("FAIL sb x=%0d got tim=%0d take=%0d idx=%0d clk=%0d busy=%0d exp tim=%0d take=%0d idx=%0d clk=%0d busy=%0d",
                   x, int'(g.tim), g.take, g.idx, g.pc, g.bsy,
                   int'(e.tim), e.take, e.idx, e.pc, e.bsy);
        end
      end
    end
  endtask

  // pv_mode: 0 held 1, 1 held 0, 2 random, 3 high until ev_x then low
  // ev_kind: 0 none, 1 reset pulse at ev_x, 2 x jumps to 0 at ev_x
  task automatic run_line(input bit en, input bit en_rand, input int mp, input int pv_mode,
                          input int ev_x, input int ev_kind);
    int xv = 0;
    for (int i = 0; i < FW; i++) begin
      @(negedge clk);
      if (i != 0) xv = xv + 1;
      if (ev_kind == 2 && i == ev_x) xv = 0;
      x           = 11'(xv);
      enable      = en_rand ? ($urandom_range(0, 7) != 0) : en;
      max_packets = 5'(mp);
      case (pv_mode)
        0: pkt_valid = 1'b1;
        1: pkt_valid = 1'b0;
        2: pkt_valid = ($urandom_range(0, 15) != 0);
        default: pkt_valid = (i < ev_x);
      endcase
      if (ev_kind == 1 && i == ev_x) begin
        check("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("rst_timings", int'(timings), int'(Control));
        check("rst_busy", int'(busy), 0);
        check("rst_take", int'(pkt_take), 0);
        check("rst_idx", int'(pkt_index), 0);
        check("rst_clk", int'(pkt_clk), 0);
      end
      if (ev_kind == 1 && i == ev_x + 2) rst_n = 1'b1;
    end
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; x = 11'd0; enable = 1'b0; pkt_valid = 1'b0; max_packets = 5'd0;
    fork
      model_loop();
      monitor_loop();
    join_none
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    t0 = takes; run_line(1'b1, 1'b0, 1, 0, 0, 0);
    check("takes_mp1", takes - t0, 1);
    t0 = takes; run_line(1'b1, 1'b0, 31, 0, 0, 0);
    check("takes_mp31", takes - t0, MAXP);
    t0 = takes; run_line(1'b1, 1'b0, 5, 3, 1380, 0);
    check("takes_drop", takes - t0, 3);
    t0 = takes; run_line(1'b1, 1'b0, 5, 1, 0, 0);
    check("takes_pv0", takes - t0, 0);
    t0 = takes; run_line(1'b0, 1'b0, 5, 0, 0, 0);
    check("takes_en0", takes - t0, 0);
    t0 = takes; run_line(1'b1, 1'b0, 0, 0, 0, 0);
    check("takes_mp0", takes - t0, 0);
    t0 = takes; run_line(1'b1, 1'b0, 5, 0, 1300, 1);
    check("takes_rst", takes - t0, 1);
    t0 = takes; run_line(1'b1, 1'b0, 5, 0, 0, 0);
    check("takes_after_rst", takes - t0, 5);
    t0 = takes; run_line(1'b1, 1'b0, 5, 0, 1310, 2);
    check("takes_jump", takes - t0, 1);
    t0 = takes; run_line(1'b1, 1'b0, 2, 0, 0, 0);
    check("takes_after_jump", takes - t0, 2);

    for (int k = 0; k < 8; k++) begin
      run_line(1'b1, 1'b1, int'($urandom_range(0, 31)), 2,
               int'($urandom_range(1281, 1600)), (k % 3 == 2) ? 2 : 0);
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
